// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES round-stage constants, state encoding and GF(2^8) helpers
package aes_pkg;

    localparam int STATE_W   = 128;
    localparam int COL_W     = 32;
    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_ADDK = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Multiply by x modulo 0x11B: shift within 8 bits, fold the carry back as 0x1B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ p;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_col_word.sv
// rtl/mix_col_word.sv - combinational MixColumns / InvMixColumns on one 32-bit column
module mix_col_word
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] i_col,
    input  logic             i_encrypt,
    output logic [COL_W-1:0] o_col
);

    // Row r uses the coefficient row rotated right by r.
    localparam logic [7:0] LP_FWD [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [7:0] LP_INV [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    logic [COL_W-1:0] w_fwd;
    logic [COL_W-1:0] w_inv;

    always_comb begin
        w_fwd = '0;
        w_inv = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                w_fwd[31-8*r -: 8] = w_fwd[31-8*r -: 8] ^ gmul(i_col[31-8*c -: 8], LP_FWD[2'(c - r)]);
                w_inv[31-8*r -: 8] = w_inv[31-8*r -: 8] ^ gmul(i_col[31-8*c -: 8], LP_INV[2'(c - r)]);
            end
        end
    end

    assign o_col = i_encrypt ? w_fwd : w_inv;

endmodule

// File: rtl/aes_round_stage.sv
// rtl/aes_round_stage.sv - one AES round (MixColumns/InvMixColumns + AddRoundKey) with valid/ready handshake
module aes_round_stage
    import aes_pkg::*;
#(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic [STATE_W-1:0] in_key,
    input  logic [RW-1:0]      in_round,
    input  logic               in_encrypt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic [RW-1:0]      out_round,
    output logic               out_err,
    output logic               busy
);

    localparam logic [RW-1:0] LP_NR = RW'(NR);

    state_t             r_state;
    state_t             w_state_nxt;
    state_t             w_first;
    logic [STATE_W-1:0] r_data;
    logic [STATE_W-1:0] r_key;
    logic [RW-1:0]      r_round;
    logic               r_enc;
    logic               r_err;
    logic [STATE_W-1:0] w_mix;
    logic               w_xfer;
    logic               w_in_illegal;
    logic               w_in_mid;
    logic               w_r_mid;

    assign in_ready     = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
    assign w_xfer       = in_valid && in_ready;
    assign w_in_illegal = in_round > LP_NR;
    assign w_in_mid     = (in_round != '0) && (in_round < LP_NR);
    assign w_r_mid      = (r_round != '0) && (r_round < LP_NR);

    for (genvar g = 0; g < 4; g++) begin : g_col
        mix_col_word u_mix (
            .i_col     (r_data[STATE_W-1-COL_W*g -: COL_W]),
            .i_encrypt (r_enc),
            .o_col     (w_mix[STATE_W-1-COL_W*g -: COL_W])
        );
    end

    // First state of a newly accepted job; illegal rounds skip straight to HOLD.
    always_comb begin
        w_first = ST_ADDK;
        if (w_in_illegal) begin
            w_first = ST_HOLD;
        end else if (w_in_mid && in_encrypt) begin
            w_first = ST_MIX;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = w_first;
                end
            end
            ST_MIX: begin
                w_state_nxt = r_enc ? ST_ADDK : ST_HOLD;
            end
            ST_ADDK: begin
                w_state_nxt = (!r_enc && w_r_mid) ? ST_MIX : ST_HOLD;
            end
            ST_HOLD: begin
                if (w_xfer) begin
                    w_state_nxt = w_first;
                end else if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_key   <= '0;
            r_round <= '0;
            r_enc   <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_xfer) begin
            r_data  <= in_data;
            r_key   <= in_key;
            r_round <= in_round;
            r_enc   <= in_encrypt;
            r_err   <= w_in_illegal;
        end else begin
            case (r_state)
                ST_MIX:  r_data <= w_mix;
                ST_ADDK: r_data <= r_data ^ r_key;
                default: r_data <= r_data;
            endcase
        end
    end

    assign out_valid = (r_state == ST_HOLD);
    assign out_data  = r_data;
    assign out_round = r_round;
    assign out_err   = r_err;
    assign busy      = (r_state != ST_IDLE);

endmodule
